// File: rtl/pal_timing_pkg.sv
// Shared PAL timing definitions: pulse-type encoding, default clock counts,
// key half-line indices and the per-half-line pulse-type lookup.
package pal_timing_pkg;

    localparam int unsigned DEF_HALF_LINE_CLKS = 3200;
    localparam int unsigned DEF_HSYNC_CLKS     = 470;
    localparam int unsigned DEF_EQ_CLKS        = 235;
    localparam int unsigned DEF_BROAD_CLKS     = 2730;

    // Half-line indices where each field begins and where the frame wraps
    localparam int unsigned H_FIELD1_START = 0;
    localparam int unsigned H_FIELD2_START = 625;
    localparam int unsigned H_LAST         = 1249;

    typedef enum logic [1:0] {
        PULSE_NONE  = 2'd0,
        PULSE_HSYNC = 2'd1,
        PULSE_EQ    = 2'd2,
        PULSE_BROAD = 2'd3
    } pulse_t;

    // Line number is h/2+1; odd h is the second half of that line.
    function automatic pulse_t pulse_type(input logic [10:0] h);
        logic [9:0] ln;
        logic       s;
        pulse_t     t;
        ln = 10'(h >> 1) + 10'd1;
        s  = h[0];
        if (ln <= 10'd2)        t = PULSE_BROAD;
        else if (ln == 10'd3)   t = s ? PULSE_EQ : PULSE_BROAD;
        else if (ln <= 10'd5)   t = PULSE_EQ;
        else if (ln <= 10'd310) t = s ? PULSE_NONE : PULSE_HSYNC;
        else if (ln <= 10'd312) t = PULSE_EQ;
        else if (ln == 10'd313) t = s ? PULSE_BROAD : PULSE_EQ;
        else if (ln <= 10'd315) t = PULSE_BROAD;
        else if (ln <= 10'd317) t = PULSE_EQ;
        else if (ln == 10'd318) t = s ? PULSE_NONE : PULSE_EQ;
        else if (ln <= 10'd622) t = s ? PULSE_NONE : PULSE_HSYNC;
        else if (ln == 10'd623) t = s ? PULSE_EQ : PULSE_HSYNC;
        else                    t = PULSE_EQ;
        return t;
    endfunction

endpackage

// File: rtl/pal_csync_generator_if.sv
// Sync output bundle: run control into the generator, composite sync and
// line/field position out of it.
interface pal_csync_generator_if;
    logic       enable;
    logic       csync;
    logic [9:0] line_number;
    logic       field;
    logic       line_start;
    logic       field_start;

    modport master (
        input  enable,
        output csync, line_number, field, line_start, field_start
    );

    modport slave (
        output enable,
        input  csync, line_number, field, line_start, field_start
    );
endinterface

// File: rtl/pal_halfline_timebase.sv
// Clock-within-half-line (c) and half-line-within-frame (h) counters.
// Held at the frame origin while enable is low.
module pal_halfline_timebase
    import pal_timing_pkg::*;
#(
    parameter int unsigned HALF_LINE_CLKS = DEF_HALF_LINE_CLKS
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic        enable,
    output logic [11:0] c,
    output logic [10:0] h,
    output logic        half_wrap
);

    localparam logic [11:0] C_LAST = 12'(HALF_LINE_CLKS - 1);
    localparam logic [10:0] H_MAX  = 11'(H_LAST);

    assign half_wrap = enable && (c == C_LAST);

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            c <= '0;
            h <= '0;
        end else if (!enable) begin
            c <= '0;
            h <= '0;
        end else if (half_wrap) begin
            c <= '0;
            h <= (h == H_MAX) ? '0 : h + 11'd1;
        end else begin
            c <= c + 12'd1;
        end
    end

endmodule

// File: rtl/pal_csync_generator.sv
// Interlaced 625-line PAL composite sync generator with registered
// line/field position and start strobes.
module pal_csync_generator
    import pal_timing_pkg::*;
#(
    parameter int unsigned HALF_LINE_CLKS = DEF_HALF_LINE_CLKS,
    parameter int unsigned HSYNC_CLKS     = DEF_HSYNC_CLKS,
    parameter int unsigned EQ_CLKS        = DEF_EQ_CLKS,
    parameter int unsigned BROAD_CLKS     = DEF_BROAD_CLKS
) (
    input  logic                   clk_100mhz,
    input  logic                   reset,
    pal_csync_generator_if.master  sync_if
);

    localparam logic [11:0] LEN_HSYNC = 12'(HSYNC_CLKS);
    localparam logic [11:0] LEN_EQ    = 12'(EQ_CLKS);
    localparam logic [11:0] LEN_BROAD = 12'(BROAD_CLKS);
    localparam logic [10:0] H_F1      = 11'(H_FIELD1_START);
    localparam logic [10:0] H_F2      = 11'(H_FIELD2_START);

    function automatic logic [11:0] pulse_len(input pulse_t t);
        logic [11:0] len;
        case (t)
            PULSE_HSYNC: len = LEN_HSYNC;
            PULSE_EQ:    len = LEN_EQ;
            PULSE_BROAD: len = LEN_BROAD;
            default:     len = 12'd0;
        endcase
        return len;
    endfunction

    logic [11:0] c_p0;
    logic [10:0] h_p0;
    logic        half_wrap_p0;
    logic        half_start_p0;
    pulse_t      type_p0;
    logic [11:0] len_p0;

    logic        csync_p1;
    logic [9:0]  line_number_p1;
    logic        field_p1;
    logic        line_start_p1;
    logic        field_start_p1;

    pal_halfline_timebase #(
        .HALF_LINE_CLKS (HALF_LINE_CLKS)
    ) u_timebase (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .enable     (sync_if.enable),
        .c          (c_p0),
        .h          (h_p0),
        .half_wrap  (half_wrap_p0)
    );

    // Stage p0: counter state decoded into the pulse length for this half line.
    // half_start_p0 tracks c==0: true after reset/hold and the cycle after a wrap.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset)                half_start_p0 <= 1'b1;
        else if (!sync_if.enable) half_start_p0 <= 1'b1;
        else                      half_start_p0 <= half_wrap_p0;
    end

    assign type_p0 = pulse_type(h_p0);
    assign len_p0  = pulse_len(type_p0);

    // Stage p1: registered outputs, one cycle behind the counters.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            csync_p1       <= 1'b1;
            line_number_p1 <= 10'd1;
            field_p1       <= 1'b0;
            line_start_p1  <= 1'b0;
            field_start_p1 <= 1'b0;
        end else if (!sync_if.enable) begin
            csync_p1       <= 1'b1;
            line_number_p1 <= 10'd1;
            field_p1       <= 1'b0;
            line_start_p1  <= 1'b0;
            field_start_p1 <= 1'b0;
        end else begin
            csync_p1       <= ~(c_p0 < len_p0);
            line_number_p1 <= 10'(h_p0 >> 1) + 10'd1;
            field_p1       <= (h_p0 >= H_F2);
            line_start_p1  <= half_start_p0 && !h_p0[0];
            field_start_p1 <= half_start_p0 && ((h_p0 == H_F1) || (h_p0 == H_F2));
        end
    end

    assign sync_if.csync       = csync_p1;
    assign sync_if.line_number = line_number_p1;
    assign sync_if.field       = field_p1;
    assign sync_if.line_start  = line_start_p1;
    assign sync_if.field_start = field_start_p1;

endmodule

// File: tb/tb_pal_csync_generator.sv
// Directed bench for pal_csync_generator using scaled-down timing
// (32 clocks per half line) so a whole frame fits in a short run.
module tb_pal_csync_generator;

    localparam int HALF = 32;
    localparam int HS   = 5;
    localparam int EQ   = 2;
    localparam int BR   = 27;

    logic clk_100mhz = 1'b0;
    logic reset      = 1'b1;

    pal_csync_generator_if sif();

    pal_csync_generator #(
        .HALF_LINE_CLKS (HALF),
        .HSYNC_CLKS     (HS),
        .EQ_CLKS        (EQ),
        .BROAD_CLKS     (BR)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .sync_if    (sif)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int passed = 0;
    int total  = 0;
    int n      = 0;
    int ls_cnt = 0;
    int cyc    = 0;
    int lows;
    int fs_stamp[$];

    always @(posedge clk_100mhz) begin
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL watchdog observed=%0d cycles required<=60000", cyc);
            $fatal(1, "cycle budget exhausted");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // After n ticks the outputs reflect counter time t = n-1.
    task automatic tick();
        @(posedge clk_100mhz);
        #1;
        n++;
        if (sif.line_start)  ls_cnt++;
        if (sif.field_start) fs_stamp.push_back(n);
    endtask

    task automatic to_t(input int t);
        while (n < t + 1) tick();
    endtask

    task automatic count_lows(input int t0, input int len, output int cnt);
        cnt = 0;
        for (int t = t0; t < t0 + len; t++) begin
            to_t(t);
            if (!sif.csync) cnt++;
        end
    endtask

    initial begin
        sif.enable = 1'b0;
        repeat (3) @(posedge clk_100mhz);
        #1;
        check("rst_csync",       32'(sif.csync),       32'd1);
        check("rst_line_number", 32'(sif.line_number), 32'd1);
        check("rst_field",       32'(sif.field),       32'd0);
        check("rst_line_start",  32'(sif.line_start),  32'd0);
        check("rst_field_start", 32'(sif.field_start), 32'd0);

        @(negedge clk_100mhz);
        reset = 1'b0;
        tick();
        check("idle_csync", 32'(sif.csync), 32'd1);

        // Start of frame: line 1 begins with a broad pulse
        n = 0; ls_cnt = 0; fs_stamp.delete();
        sif.enable = 1'b1;
        to_t(0);
        check("t0_csync",       32'(sif.csync),       32'd0);
        check("t0_line_start",  32'(sif.line_start),  32'd1);
        check("t0_field_start", 32'(sif.field_start), 32'd1);
        check("t0_line_number", 32'(sif.line_number), 32'd1);
        check("t0_field",       32'(sif.field),       32'd0);
        to_t(1);
        check("t1_line_start",  32'(sif.line_start),  32'd0);
        check("t1_field_start", 32'(sif.field_start), 32'd0);
        to_t(BR - 1);
        check("broad_last_low", 32'(sif.csync), 32'd0);
        to_t(BR);
        check("broad_high",     32'(sif.csync), 32'd1);
        to_t(HALF - 1);
        check("broad_tail_high", 32'(sif.csync), 32'd1);
        to_t(HALF);
        check("l1h1_csync",      32'(sif.csync),      32'd0);
        check("l1h1_line_start", 32'(sif.line_start), 32'd0);

        // Line 3: broad then equalising
        to_t(4 * HALF);
        check("l3_line_number", 32'(sif.line_number), 32'd3);
        count_lows(4 * HALF, HALF, lows);
        check("l3h0_lows", 32'(lows), 32'(BR));
        count_lows(5 * HALF, HALF, lows);
        check("l3h1_lows", 32'(lows), 32'(EQ));

        // Line 100: one hsync, no mid-line pulse
        to_t(198 * HALF);
        check("l100_csync",       32'(sif.csync),       32'd0);
        check("l100_line_start",  32'(sif.line_start),  32'd1);
        check("l100_line_number", 32'(sif.line_number), 32'd100);
        to_t(198 * HALF + HS - 1);
        check("l100_last_low", 32'(sif.csync), 32'd0);
        to_t(198 * HALF + HS);
        check("l100_rise", 32'(sif.csync), 32'd1);
        count_lows(198 * HALF + HS + 1, 2 * HALF - HS - 1, lows);
        check("l100_rest_lows", 32'(lows), 32'd0);

        // Line 313: eq then broad, second field starts at the half-line
        to_t(624 * HALF);
        check("l313_line_number", 32'(sif.line_number), 32'd313);
        check("l313_field_h0",    32'(sif.field),       32'd0);
        count_lows(624 * HALF, HALF, lows);
        check("l313h0_lows", 32'(lows), 32'(EQ));
        to_t(625 * HALF);
        check("l313h1_field_start", 32'(sif.field_start), 32'd1);
        check("l313h1_field",       32'(sif.field),       32'd1);
        check("l313h1_line_start",  32'(sif.line_start),  32'd0);
        count_lows(625 * HALF, HALF, lows);
        check("l313h1_lows", 32'(lows), 32'(BR));

        // Line 623..625 and the frame wrap
        to_t(1244 * HALF);
        check("l623_line_number", 32'(sif.line_number), 32'd623);
        check("l623_field",       32'(sif.field),       32'd1);
        count_lows(1244 * HALF, HALF, lows);
        check("l623h0_lows", 32'(lows), 32'(HS));
        count_lows(1245 * HALF, HALF, lows);
        check("l623h1_lows", 32'(lows), 32'(EQ));
        count_lows(1246 * HALF, 4 * HALF, lows);
        check("l624_625_lows", 32'(lows), 32'(4 * EQ));
        check("l625_line_number", 32'(sif.line_number), 32'd625);
        check("frame_line_starts", 32'(ls_cnt), 32'd625);
        to_t(1250 * HALF);
        check("wrap_line_number", 32'(sif.line_number), 32'd1);
        check("wrap_field",       32'(sif.field),       32'd0);
        check("wrap_field_start", 32'(sif.field_start), 32'd1);
        check("wrap_line_start",  32'(sif.line_start),  32'd1);
        check("wrap_csync",       32'(sif.csync),       32'd0);
        check("field_start_count", 32'(fs_stamp.size()), 32'd3);
        if (fs_stamp.size() == 3) begin
            check("field2_start_time", 32'(fs_stamp[1]), 32'(625 * HALF + 1));
            check("frame_period",      32'(fs_stamp[2] - fs_stamp[0]), 32'(1250 * HALF));
        end

        // Disable mid-broad, then re-enable
        to_t(1250 * HALF + 10);
        check("pre_dis_csync", 32'(sif.csync), 32'd0);
        sif.enable = 1'b0;
        tick();
        check("dis_csync",       32'(sif.csync),       32'd1);
        check("dis_line_number", 32'(sif.line_number), 32'd1);
        check("dis_line_start",  32'(sif.line_start),  32'd0);
        tick();
        tick();
        check("dis_hold_csync", 32'(sif.csync), 32'd1);
        n = 0;
        sif.enable = 1'b1;
        tick();
        check("reen_csync",       32'(sif.csync),       32'd0);
        check("reen_field_start", 32'(sif.field_start), 32'd1);
        check("reen_line_start",  32'(sif.line_start),  32'd1);

        // Async reset mid-broad on line 2, then restart
        to_t(2 * HALF + 10);
        check("pre_rst_csync",       32'(sif.csync),       32'd0);
        check("pre_rst_line_number", 32'(sif.line_number), 32'd2);
        reset = 1'b1;
        #1;
        check("async_rst_csync",       32'(sif.csync),       32'd1);
        check("async_rst_line_number", 32'(sif.line_number), 32'd1);
        @(negedge clk_100mhz);
        reset = 1'b0;
        n = 0;
        tick();
        check("post_rst_csync",       32'(sif.csync),       32'd0);
        check("post_rst_field_start", 32'(sif.field_start), 32'd1);
        check("post_rst_line_number", 32'(sif.line_number), 32'd1);
        to_t(BR);
        check("post_rst_broad_high", 32'(sif.csync), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
